// File: rtl/fruit_juicer.sv
// rtl/fruit_juicer.sv - selectable fruit accumulator with threshold pour handshake
module fruit_juicer #(
    parameter int N      = 2,
    parameter int FW     = 1,
    parameter int W      = 3,
    parameter int INIT   = 5,
    parameter int SAT    = 0,
    parameter int THRESH = 0,
    localparam int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW-1:0]     sel,
    input  logic [N*FW-1:0]   fruit,
    input  logic              fruit_valid,
    output logic              fruit_ready,
    input  logic              load,
    input  logic [W-1:0]      water,
    output logic [W-1:0]      juice,
    output logic              juice_valid,
    input  logic              juice_ready,
    output logic              overflow
);

    typedef enum logic {FILL, POUR} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  bowl, bowl_nxt;
    logic          ovf, ovf_nxt;
    logic [FW-1:0] sel_val;
    logic [W:0]    sum;
    logic          wr;

    // Out-of-range selects fall through to zero.
    always_comb begin
        sel_val = '0;
        for (int k = 0; k < N; k++) begin
            if (sel == SW'(k)) sel_val = fruit[k*FW +: FW];
        end
    end

    assign sum = {1'b0, bowl} + {1'b0, W'(sel_val)};

    always_comb begin
        bowl_nxt  = bowl;
        ovf_nxt   = ovf;
        state_nxt = state;
        wr        = 1'b0;
        if (load) begin
            bowl_nxt  = water;
            ovf_nxt   = 1'b0;
            state_nxt = FILL;
            wr        = 1'b1;
        end else if (state == POUR) begin
            if (juice_ready) begin
                bowl_nxt  = W'(INIT);
                state_nxt = FILL;
            end
        end else if (fruit_valid) begin
            wr = 1'b1;
            if (sum[W]) begin
                ovf_nxt  = 1'b1;
                bowl_nxt = (SAT != 0) ? '1 : sum[W-1:0];
            end else begin
                bowl_nxt = sum[W-1:0];
            end
        end
        // Only fresh writes can start a pour; the refill after an accept cannot.
        if (wr && (THRESH != 0) && (32'(bowl_nxt) >= THRESH)) state_nxt = POUR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            bowl  <= W'(INIT);
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            bowl  <= bowl_nxt;
            ovf   <= ovf_nxt;
        end
    end

    assign juice       = bowl;
    assign overflow    = ovf;
    assign juice_valid = (state == POUR);
    assign fruit_ready = (state == FILL);

endmodule

// File: tb/tb_fruit_juicer.sv
// tb/tb_fruit_juicer.sv - table-driven checks of fruit_juicer in four configurations
module tb_fruit_juicer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // d0: defaults (wrap), d1: defaults with SAT=1; both share inputs
    logic       rst01, sel01, fv01, load01, jr01;
    logic [1:0] fruit01;
    logic [2:0] water01;
    logic [2:0] j0, j1;
    logic       jv0, jv1, fr0, fr1, o0, o1;

    fruit_juicer d0 (.clk(clk), .rst(rst01), .sel(sel01), .fruit(fruit01),
        .fruit_valid(fv01), .fruit_ready(fr0), .load(load01), .water(water01),
        .juice(j0), .juice_valid(jv0), .juice_ready(jr01), .overflow(o0));

    fruit_juicer #(.SAT(1)) d1 (.clk(clk), .rst(rst01), .sel(sel01), .fruit(fruit01),
        .fruit_valid(fv01), .fruit_ready(fr1), .load(load01), .water(water01),
        .juice(j1), .juice_valid(jv1), .juice_ready(jr01), .overflow(o1));

    // d2: pouring configuration
    logic        rst2, fv2, load2, jr2;
    logic [1:0]  sel2;
    logic [15:0] fruit2;
    logic [7:0]  water2, j2;
    logic        jv2, fr2, o2;

    fruit_juicer #(.N(4), .FW(4), .W(8), .INIT(0), .THRESH(20)) d2 (.clk(clk), .rst(rst2),
        .sel(sel2), .fruit(fruit2), .fruit_valid(fv2), .fruit_ready(fr2), .load(load2),
        .water(water2), .juice(j2), .juice_valid(jv2), .juice_ready(jr2), .overflow(o2));

    // d3: three channels, so sel=3 is out of range
    logic       rst3, fv3, load3, jr3;
    logic [1:0] sel3;
    logic [5:0] fruit3;
    logic [3:0] water3, j3;
    logic       jv3, fr3, o3;

    fruit_juicer #(.N(3), .FW(2), .W(4), .INIT(1)) d3 (.clk(clk), .rst(rst3),
        .sel(sel3), .fruit(fruit3), .fruit_valid(fv3), .fruit_ready(fr3), .load(load3),
        .water(water3), .juice(j3), .juice_valid(jv3), .juice_ready(jr3), .overflow(o3));

    typedef struct {
        int rst, sel, fruit, fv, load, water;
        int ej0, eo0, ej1, eo1;
    } v01_t;

    typedef struct {
        int rst, sel, fruit, fv, load, water, jr;
        int ej, ejv, efr;
    } v2_t;

    v01_t t01[12];
    v2_t  t2[18];

    initial begin
        rst01 = 1; sel01 = 0; fv01 = 0; load01 = 0; jr01 = 0; fruit01 = 0; water01 = 0;
        rst2 = 1; sel2 = 0; fv2 = 0; load2 = 0; jr2 = 0; fruit2 = 0; water2 = 0;
        rst3 = 1; sel3 = 0; fv3 = 0; load3 = 0; jr3 = 0; fruit3 = 0; water3 = 0;

        //          rst sel fr fv ld  w  j0 o0 j1 o1
        t01[0]  = '{1, 0, 0, 0, 0, 0, 5, 0, 5, 0};
        t01[1]  = '{0, 1, 2, 1, 0, 0, 6, 0, 6, 0};
        t01[2]  = '{0, 1, 2, 1, 0, 0, 7, 0, 7, 0};
        t01[3]  = '{0, 1, 2, 1, 0, 0, 0, 1, 7, 1};
        t01[4]  = '{0, 1, 2, 1, 0, 0, 1, 1, 7, 1};
        t01[5]  = '{0, 0, 2, 1, 0, 0, 1, 1, 7, 1};
        t01[6]  = '{0, 1, 2, 1, 1, 3, 3, 0, 3, 0};
        t01[7]  = '{0, 1, 2, 0, 0, 0, 3, 0, 3, 0};
        t01[8]  = '{0, 1, 3, 1, 0, 0, 4, 0, 4, 0};
        t01[9]  = '{0, 1, 2, 0, 1, 7, 7, 0, 7, 0};
        t01[10] = '{0, 1, 2, 1, 0, 0, 0, 1, 7, 1};
        t01[11] = '{1, 1, 2, 1, 0, 0, 5, 0, 5, 0};

        //          rst sel fruit fv ld  w  jr  j  jv fr
        t2[0]  = '{1, 0, 0,     0, 0, 0, 0,  0, 0, 1};
        t2[1]  = '{0, 2, 16'h0700, 1, 0, 0, 0,  7, 0, 1};
        t2[2]  = '{0, 2, 16'h0700, 1, 0, 0, 0, 14, 0, 1};
        t2[3]  = '{0, 2, 16'h0700, 1, 0, 0, 0, 21, 1, 0};
        t2[4]  = '{0, 2, 16'h0700, 1, 0, 0, 0, 21, 1, 0};
        t2[5]  = '{0, 2, 16'h0700, 1, 0, 0, 0, 21, 1, 0};
        t2[6]  = '{0, 2, 16'h0700, 1, 0, 0, 0, 21, 1, 0};
        t2[7]  = '{0, 2, 16'h0700, 1, 0, 0, 0, 21, 1, 0};
        t2[8]  = '{0, 2, 16'h0700, 1, 0, 0, 0, 21, 1, 0};
        t2[9]  = '{0, 2, 16'h0700, 1, 0, 0, 1,  0, 0, 1};
        t2[10] = '{0, 2, 16'h0700, 0, 0, 0, 0,  0, 0, 1};
        t2[11] = '{0, 2, 16'h0700, 0, 1, 25, 0, 25, 1, 0};
        t2[12] = '{0, 2, 16'h0700, 0, 1, 4, 1,  4, 0, 1};
        t2[13] = '{0, 2, 16'h0700, 1, 0, 0, 0, 11, 0, 1};
        t2[14] = '{0, 2, 16'h0700, 1, 0, 0, 0, 18, 0, 1};
        t2[15] = '{0, 2, 16'h0700, 1, 0, 0, 0, 25, 1, 0};
        t2[16] = '{1, 2, 16'h0700, 1, 0, 0, 0,  0, 0, 1};
        t2[17] = '{0, 1, 16'h0050, 1, 0, 0, 0,  5, 0, 1};

        for (int i = 0; i < 12; i++) begin
            rst01   = 1'(t01[i].rst);
            sel01   = 1'(t01[i].sel);
            fruit01 = 2'(t01[i].fruit);
            fv01    = 1'(t01[i].fv);
            load01  = 1'(t01[i].load);
            water01 = 3'(t01[i].water);
            @(posedge clk); #1;
            chk($sformatf("wrap_juice[%0d]", i), int'(j0), t01[i].ej0);
            chk($sformatf("wrap_ovf[%0d]", i), int'(o0), t01[i].eo0);
            chk($sformatf("sat_juice[%0d]", i), int'(j1), t01[i].ej1);
            chk($sformatf("sat_ovf[%0d]", i), int'(o1), t01[i].eo1);
            chk($sformatf("nothresh_jv[%0d]", i), int'(jv0), 0);
            chk($sformatf("nothresh_fr[%0d]", i), int'(fr1), 1);
        end

        for (int i = 0; i < 18; i++) begin
            rst2   = 1'(t2[i].rst);
            sel2   = 2'(t2[i].sel);
            fruit2 = 16'(t2[i].fruit);
            fv2    = 1'(t2[i].fv);
            load2  = 1'(t2[i].load);
            water2 = 8'(t2[i].water);
            jr2    = 1'(t2[i].jr);
            @(posedge clk); #1;
            chk($sformatf("pour_juice[%0d]", i), int'(j2), t2[i].ej);
            chk($sformatf("pour_jv[%0d]", i), int'(jv2), t2[i].ejv);
            chk($sformatf("pour_fr[%0d]", i), int'(fr2), t2[i].efr);
            chk($sformatf("pour_ovf[%0d]", i), int'(o2), 0);
        end

        // out-of-range select on a three-channel block
        rst3 = 1; @(posedge clk); #1;
        chk("n3_reset", int'(j3), 1);
        rst3 = 0; fruit3 = 6'b11_10_01; sel3 = 2; fv3 = 1;
        @(posedge clk); #1;
        chk("n3_sel2", int'(j3), 4);
        sel3 = 3;
        @(posedge clk); #1;
        chk("n3_sel3_juice", int'(j3), 4);
        chk("n3_sel3_ovf", int'(o3), 0);
        sel3 = 0;
        @(posedge clk); #1;
        chk("n3_sel0", int'(j3), 5);
        fv3 = 0; load3 = 1; water3 = 4'd15;
        @(posedge clk); #1;
        load3 = 0; fv3 = 1; sel3 = 1;
        @(posedge clk); #1;
        chk("n3_wrap_juice", int'(j3), 1);
        chk("n3_wrap_ovf", int'(o3), 1);
        chk("n3_no_pour", int'(jv3), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
